// File: rtl/jt10_adpcm_rom.sv
// ADPCM-A sample ROM fetch unit: per-channel byte cache, single-outstanding ROM
// fetch arbiter and a one-slot-latency nibble output stage.
module jt10_adpcm_rom (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cen,
   input  logic [5:0]  cur_ch,
   input  logic [19:0] addr_in,
   input  logic [3:0]  bank,
   input  logic        sel,
   input  logic        roe_n,
   input  logic        decon,
   input  logic        clr,
   output logic [23:0] rom_addr,
   output logic        rom_cs,
   input  logic [7:0]  rom_data,
   input  logic        rom_ok,
   output logic [3:0]  nib_out,
   output logic        nib_valid,
   output logic [5:0]  out_ch,
   output logic        underrun,
   input  logic        clr_underrun
);

   typedef enum logic {StIdle, StBusy} state_e;

   state_e           st_q, st_d;
   logic [5:0][23:0] tag_q, tag_d;
   logic [5:0][7:0]  data_q, data_d;
   logic [5:0]       valid_q, valid_d;
   logic [5:0]       pending_q, pending_d;
   logic [2:0]       rr_q, rr_d;
   logic [2:0]       fetch_ch_q, fetch_ch_d;
   logic [23:0]      rom_addr_q, rom_addr_d;
   logic             rom_cs_q, rom_cs_d;
   logic [5:0]       req_ch_q, req_ch_d;
   logic             req_sel_q, req_sel_d;
   logic             req_rd_q, req_rd_d;
   logic             req_dec_q, req_dec_d;
   logic [3:0]       nib_q, nib_d;
   logic             nib_valid_q, nib_valid_d;
   logic [5:0]       out_ch_q, out_ch_d;
   logic             underrun_q, underrun_d;

   logic [2:0]  cur_idx, req_idx, pick_idx;
   logic        cur_ok, pick_ok, fetch_hit, bypass, byte_ok, und_set;
   logic [23:0] req_addr;
   logic [7:0]  out_byte;

   function automatic logic [2:0] onehot_idx(input logic [5:0] v);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 6; i++) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   function automatic logic [2:0] rr_idx(input logic [2:0] base, input logic [2:0] off);
      logic [3:0] s;
      s = {1'b0, base} + {1'b0, off};
      return (s >= 4'd6) ? 3'(s - 4'd6) : s[2:0];
   endfunction

   assign cur_idx  = onehot_idx(cur_ch);
   assign req_idx  = onehot_idx(req_ch_q);
   assign cur_ok   = $onehot(cur_ch);
   assign req_addr = {bank, addr_in};

   // rom_addr_q holds the in-flight fetch address; a re-tagged entry rejects it
   assign fetch_hit = (st_q == StBusy) && rom_ok && pending_q[fetch_ch_q] &&
                      (tag_q[fetch_ch_q] == rom_addr_q);
   assign bypass    = fetch_hit && (fetch_ch_q == req_idx);

   always_comb begin
      pick_ok  = 1'b0;
      pick_idx = '0;
      // descending scan so the nearest channel after the pointer wins
      for (int j = 5; j >= 0; j--) begin
         if (pending_q[rr_idx(rr_q, 3'(j))]) begin
            pick_ok  = 1'b1;
            pick_idx = rr_idx(rr_q, 3'(j));
         end
      end
   end

   always_comb begin
      byte_ok  = 1'b0;
      out_byte = '0;
      if (valid_q[req_idx]) begin
         byte_ok  = 1'b1;
         out_byte = data_q[req_idx];
      end else if (bypass) begin
         byte_ok  = 1'b1;
         out_byte = rom_data;
      end
   end

   always_comb begin
      st_d        = st_q;
      tag_d       = tag_q;
      data_d      = data_q;
      valid_d     = valid_q;
      pending_d   = pending_q;
      rr_d        = rr_q;
      fetch_ch_d  = fetch_ch_q;
      rom_addr_d  = rom_addr_q;
      rom_cs_d    = rom_cs_q;
      req_ch_d    = req_ch_q;
      req_sel_d   = req_sel_q;
      req_rd_d    = req_rd_q;
      req_dec_d   = req_dec_q;
      nib_d       = nib_q;
      nib_valid_d = nib_valid_q;
      out_ch_d    = out_ch_q;
      und_set     = 1'b0;

      unique case (st_q)
         StIdle: begin
            if (pick_ok) begin
               st_d       = StBusy;
               rom_cs_d   = 1'b1;
               rom_addr_d = tag_q[pick_idx];
               fetch_ch_d = pick_idx;
               rr_d       = (pick_idx == 3'd5) ? 3'd0 : pick_idx + 3'd1;
            end
         end
         StBusy: begin
            if (rom_ok) begin
               st_d     = StIdle;
               rom_cs_d = 1'b0;
            end
         end
         default: st_d = StIdle;
      endcase

      if (fetch_hit) begin
         data_d[fetch_ch_q]    = rom_data;
         valid_d[fetch_ch_q]   = 1'b1;
         pending_d[fetch_ch_q] = 1'b0;
      end

      // a request in the same clk as a fill overrides it
      if (cen && cur_ok) begin
         if (!roe_n) begin
            if (clr || (req_addr != tag_q[cur_idx])) begin
               tag_d[cur_idx]     = req_addr;
               valid_d[cur_idx]   = 1'b0;
               pending_d[cur_idx] = 1'b1;
            end
         end else if (clr) begin
            valid_d[cur_idx]   = 1'b0;
            pending_d[cur_idx] = 1'b0;
         end
      end

      if (cen) begin
         req_ch_d    = cur_ok ? cur_ch : 6'd0;
         req_sel_d   = sel;
         req_rd_d    = cur_ok & ~roe_n;
         req_dec_d   = cur_ok & decon;
         out_ch_d    = req_ch_q;
         nib_valid_d = req_dec_q;
         nib_d       = '0;
         if (req_rd_q) begin
            if (byte_ok) nib_d = req_sel_q ? out_byte[3:0] : out_byte[7:4];
            else         und_set = 1'b1;
         end
      end

      if (und_set)           underrun_d = 1'b1;
      else if (clr_underrun) underrun_d = 1'b0;
      else                   underrun_d = underrun_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q        <= StIdle;
         tag_q       <= '0;
         data_q      <= '0;
         valid_q     <= '0;
         pending_q   <= '0;
         rr_q        <= '0;
         fetch_ch_q  <= '0;
         rom_addr_q  <= '0;
         rom_cs_q    <= 1'b0;
         req_ch_q    <= '0;
         req_sel_q   <= 1'b0;
         req_rd_q    <= 1'b0;
         req_dec_q   <= 1'b0;
         nib_q       <= '0;
         nib_valid_q <= 1'b0;
         out_ch_q    <= '0;
         underrun_q  <= 1'b0;
      end else begin
         st_q        <= st_d;
         tag_q       <= tag_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         pending_q   <= pending_d;
         rr_q        <= rr_d;
         fetch_ch_q  <= fetch_ch_d;
         rom_addr_q  <= rom_addr_d;
         rom_cs_q    <= rom_cs_d;
         req_ch_q    <= req_ch_d;
         req_sel_q   <= req_sel_d;
         req_rd_q    <= req_rd_d;
         req_dec_q   <= req_dec_d;
         nib_q       <= nib_d;
         nib_valid_q <= nib_valid_d;
         out_ch_q    <= out_ch_d;
         underrun_q  <= underrun_d;
      end
   end

   assign rom_addr  = rom_addr_q;
   assign rom_cs    = rom_cs_q;
   assign nib_out   = nib_q;
   assign nib_valid = nib_valid_q;
   assign out_ch    = out_ch_q;
   assign underrun  = underrun_q;

endmodule

// File: tb/tb_jt10_adpcm_rom.sv
// Bench for jt10_adpcm_rom: slot-level model of cache hits/misses and expected
// nibbles, plus a ROM responder with programmable latency.
module tb_jt10_adpcm_rom;

   localparam int P = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cen = 1'b0;
   logic [5:0]  cur_ch = '0;
   logic [19:0] addr_in = '0;
   logic [3:0]  bank = '0;
   logic        sel = 1'b0;
   logic        roe_n = 1'b1;
   logic        decon = 1'b0;
   logic        clr = 1'b0;
   logic [23:0] rom_addr;
   logic        rom_cs;
   logic [7:0]  rom_data = '0;
   logic        rom_ok = 1'b0;
   logic [3:0]  nib_out;
   logic        nib_valid;
   logic [5:0]  out_ch;
   logic        underrun;
   logic        clr_underrun = 1'b0;

   int          n_assert = 0;
   int          n_fail = 0;
   int          lat = 5;
   logic [23:0] fq[$];
   logic [23:0] last_addr[6];
   logic [3:0]  p_nib = '0;
   logic [5:0]  p_ch = '0;
   logic        p_dec = 1'b0;
   logic        p_late = 1'b0;
   logic        late = 1'b0;
   logic        und_exp = 1'b0;

   jt10_adpcm_rom dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cen          (cen),
      .cur_ch       (cur_ch),
      .addr_in      (addr_in),
      .bank         (bank),
      .sel          (sel),
      .roe_n        (roe_n),
      .decon        (decon),
      .clr          (clr),
      .rom_addr     (rom_addr),
      .rom_cs       (rom_cs),
      .rom_data     (rom_data),
      .rom_ok       (rom_ok),
      .nib_out      (nib_out),
      .nib_valid    (nib_valid),
      .out_ch       (out_ch),
      .underrun     (underrun),
      .clr_underrun (clr_underrun)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_byte(input logic [23:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hB5;
   endfunction

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ROM model: serves each rom_cs burst after lat clk; checks fetch order
   initial begin
      logic [23:0] a, ea;
      int          l;
      forever begin
         @(negedge clk);
         if (rom_cs === 1'b1) begin
            a  = rom_addr;
            l  = lat;
            ea = (fq.size() > 0) ? fq.pop_front() : ~a;
            chk("fetch_addr", a, ea);
            for (int k = 1; k < l; k++) @(negedge clk);
            rom_data = rom_byte(a);
            rom_ok   = 1'b1;
            @(negedge clk);
            rom_ok   = 1'b0;
         end
      end
   end

   task automatic slot(input logic [5:0] ch, input logic [23:0] a, input logic s,
                       input logic rd, input logic dec, input logic c);
      logic [2:0] idx;
      logic [7:0] b;
      @(negedge clk);
      cur_ch = ch;
      {bank, addr_in} = a;
      sel = s;
      roe_n = ~rd;
      decon = dec;
      clr = c;
      cen = 1'b1;
      @(negedge clk);
      cen = 1'b0;
      clr = 1'b0;
      roe_n = 1'b1;
      decon = 1'b0;
      if (p_late) und_exp = 1'b1;
      chk("nib_out", 24'(nib_out), p_late ? 24'd0 : 24'(p_nib));
      chk("out_ch", 24'(out_ch), 24'(p_ch));
      chk("nib_valid", 24'(nib_valid), 24'(p_dec));
      chk("underrun", 24'(underrun), 24'(und_exp));
      idx = '0;
      for (int i = 0; i < 6; i++) if (ch[i]) idx = 3'(i);
      p_late = 1'b0;
      p_nib  = '0;
      if (!$onehot(ch)) begin
         p_ch  = '0;
         p_dec = 1'b0;
      end else begin
         p_ch  = ch;
         p_dec = dec;
         if (rd) begin
            if (c || (a != last_addr[idx])) begin
               fq.push_back(a);
               last_addr[idx] = a;
            end
            b      = rom_byte(a);
            p_nib  = s ? b[3:0] : b[7:4];
            p_late = late;
         end
      end
      late = 1'b0;
      repeat (P - 2) @(negedge clk);
   endtask

   task automatic clear_underrun();
      @(negedge clk);
      clr_underrun = 1'b1;
      @(negedge clk);
      clr_underrun = 1'b0;
      chk("underrun_clr", 24'(underrun), 24'd0);
      und_exp = 1'b0;
   endtask

   initial begin
      logic [5:0]  rch;
      logic [23:0] ra;
      logic        rrd;
      for (int i = 0; i < 6; i++) last_addr[i] = '0;

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_rom_cs", 24'(rom_cs), 24'd0);
      chk("rst_rom_addr", rom_addr, 24'd0);
      chk("rst_out", {14'd0, nib_out, nib_valid, out_ch, underrun}, 24'd0);
      rst_n = 1'b1;

      // cold read then cache hit on the same byte
      lat = 5;
      slot(6'b000001, 24'h000010, 1'b0, 1'b1, 1'b1, 1'b0);
      slot(6'b000001, 24'h000010, 1'b1, 1'b1, 1'b1, 1'b0);
      slot(6'b000000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);

      // six channels, distinct addresses, latency 10
      lat = 10;
      for (int i = 0; i < 6; i++)
         slot(6'(1 << i), 24'h300000 + 24'(i * 24'h111), 1'(i), 1'b1, 1'b1, 1'b0);
      slot(6'b000000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);

      // ROM withheld past next cen, then late fill serves a hit
      lat  = 40;
      late = 1'b1;
      slot(6'b000010, 24'h4A0123, 1'b0, 1'b1, 1'b1, 1'b0);
      slot(6'b000000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);
      clear_underrun();
      slot(6'b000010, 24'h4A0123, 1'b1, 1'b1, 1'b1, 1'b0);
      slot(6'b000000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);

      // re-tag mid-fetch: first byte must be discarded
      lat  = 20;
      late = 1'b1;
      slot(6'b000100, 24'h000100, 1'b1, 1'b1, 1'b1, 1'b0);
      lat = 5;
      slot(6'b000100, 24'h000200, 1'b1, 1'b1, 1'b1, 1'b1);
      slot(6'b000000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);
      clear_underrun();

      // bypass: rom_ok coincides with the output cen
      lat = 15;
      slot(6'b010000, 24'h7C0555, 1'b0, 1'b1, 1'b1, 1'b0);
      slot(6'b000000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);

      // randomized slots
      for (int n = 0; n < 150; n++) begin
         lat = $urandom_range(1, 10);
         case ($urandom_range(0, 9))
            8:       rch = 6'b000000;
            9:       rch = 6'b100100;
            default: rch = 6'(1 << $urandom_range(0, 5));
         endcase
         ra  = 24'(($urandom_range(0, 3) + 1) * 24'h150013);
         rrd = ($urandom_range(0, 4) != 0);
         slot(rch, ra, 1'($urandom_range(0, 1)), rrd, 1'($urandom_range(0, 1)),
              rrd && ($urandom_range(0, 9) == 0));
      end
      slot(6'b000000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("fetch_drain", 24'(fq.size()), 24'd0);

      // asynchronous reset during a fetch; late rom_ok ignored afterwards
      lat = 20;
      slot(6'b001000, 24'h2B0777, 1'b0, 1'b1, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_rom_cs", 24'(rom_cs), 24'd0);
      fq.delete();
      for (int i = 0; i < 6; i++) last_addr[i] = '0;
      p_nib = '0; p_ch = '0; p_dec = 1'b0; p_late = 1'b0; und_exp = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("post_rst_rom_cs", 24'(rom_cs), 24'd0);
      chk("post_rst_out", {14'd0, nib_out, nib_valid, out_ch, underrun}, 24'd0);
      lat = 5;
      slot(6'b001000, 24'h2B0777, 1'b1, 1'b1, 1'b1, 1'b0);
      slot(6'b000000, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("final_drain", 24'(fq.size()), 24'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
